// File: rtl/expression_stack_pkg.sv
// ----------------------------------------------------------------------------
// expression_stack_pkg
//   Shared command encodings for the expression-stack interface. The control
//   unit imports the same package so both sides agree on ESOp/popAmt values.
// ----------------------------------------------------------------------------
package expression_stack_pkg;

   typedef enum logic [1:0] {
      ES_PUSH = 2'b00,
      ES_POP  = 2'b01,
      ES_DUP  = 2'b10,
      ES_FLIP = 2'b11
   } es_op_e;

   localparam logic POP_ONE = 1'b0;
   localparam logic POP_TWO = 1'b1;

endpackage

// File: rtl/expression_stack_regfile.sv
// ----------------------------------------------------------------------------
// expression_stack_regfile
//   DEPTH x WIDTH storage array for the expression stack.
//   Ports:
//     i_clk                     clock, writes on rising edge
//     i_we_a/i_waddr_a/i_wdata_a  write port A
//     i_we_b/i_waddr_b/i_wdata_b  write port B (wins on equal address)
//     i_raddr_a -> o_rdata_a    asynchronous read port A
//     i_raddr_b -> o_rdata_b    asynchronous read port B
//   Contents are never reset; the top level gates reads by occupancy.
// ----------------------------------------------------------------------------
module expression_stack_regfile #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_we_a,
   input  logic [AW-1:0]    i_waddr_a,
   input  logic [WIDTH-1:0] i_wdata_a,
   input  logic             i_we_b,
   input  logic [AW-1:0]    i_waddr_b,
   input  logic [WIDTH-1:0] i_wdata_b,
   input  logic [AW-1:0]    i_raddr_a,
   output logic [WIDTH-1:0] o_rdata_a,
   input  logic [AW-1:0]    i_raddr_b,
   output logic [WIDTH-1:0] o_rdata_b
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Port B is written last so it takes priority on an address collision.
   always_ff @(posedge i_clk) begin
      if (i_we_a) r_mem[i_waddr_a] <= i_wdata_a;
      if (i_we_b) r_mem[i_waddr_b] <= i_wdata_b;
   end

   assign o_rdata_a = r_mem[i_raddr_a];
   assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/expression_stack.sv
// ----------------------------------------------------------------------------
// expression_stack
//   Operand stack for the processor, driven by the control unit's
//   ESAct/ESOp/popAmt command interface. One command per qualified edge.
//   Ports:
//     CLK, Reset_n (async, active-low)
//     ESAct, ESOp, popAmt, PushData   command inputs
//     ErrClr                          synchronous clear of error flags
//     Top, Second                     combinational views of the top two entries
//     Count, Empty, Full              occupancy
//     Overflow, Underflow             sticky error flags
// ----------------------------------------------------------------------------
module expression_stack
   import expression_stack_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
   input  logic             CLK,
   input  logic             Reset_n,
   input  logic             ESAct,
   input  logic [1:0]       ESOp,
   input  logic             popAmt,
   input  logic [WIDTH-1:0] PushData,
   input  logic             ErrClr,
   output logic [WIDTH-1:0] Top,
   output logic [WIDTH-1:0] Second,
   output logic [CW-1:0]    Count,
   output logic             Empty,
   output logic             Full,
   output logic             Overflow,
   output logic             Underflow
);

   localparam int unsigned AW = CW - 1;

   logic [CW-1:0]    r_count, w_count_d;
   logic             r_ovf, r_uf;
   logic             w_ovf_set, w_uf_set;
   logic             w_we_a, w_we_b;
   logic [AW-1:0]    w_waddr_a, w_waddr_b;
   logic [WIDTH-1:0] w_wdata_a, w_wdata_b;
   logic [AW-1:0]    w_top_idx, w_sec_idx, w_push_idx;
   logic [WIDTH-1:0] w_rd_top, w_rd_sec;
   logic             w_empty, w_full, w_ge2;

   // Indices wrap modulo DEPTH; the occupancy gating below hides stale reads.
   assign w_push_idx = r_count[AW-1:0];
   assign w_top_idx  = AW'(r_count[AW-1:0] - AW'(1));
   assign w_sec_idx  = AW'(r_count[AW-1:0] - AW'(2));

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CW'(DEPTH));
   assign w_ge2   = (r_count >= CW'(2));

   expression_stack_regfile #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_regfile (
      .i_clk     (CLK),
      .i_we_a    (w_we_a),
      .i_waddr_a (w_waddr_a),
      .i_wdata_a (w_wdata_a),
      .i_we_b    (w_we_b),
      .i_waddr_b (w_waddr_b),
      .i_wdata_b (w_wdata_b),
      .i_raddr_a (w_top_idx),
      .o_rdata_a (w_rd_top),
      .i_raddr_b (w_sec_idx),
      .o_rdata_b (w_rd_sec)
   );

   assign Top    = w_empty ? '0 : w_rd_top;
   assign Second = w_ge2   ? w_rd_sec : '0;

   always_comb begin
      w_count_d = r_count;
      w_ovf_set = 1'b0;
      w_uf_set  = 1'b0;
      w_we_a    = 1'b0;
      w_we_b    = 1'b0;
      w_waddr_a = w_push_idx;
      w_waddr_b = w_sec_idx;
      w_wdata_a = PushData;
      w_wdata_b = Top;
      if (ESAct) begin
         unique case (es_op_e'(ESOp))
            ES_PUSH: begin
               if (w_full) begin
                  w_ovf_set = 1'b1;
               end else begin
                  w_we_a    = 1'b1;
                  w_count_d = r_count + CW'(1);
               end
            end
            ES_POP: begin
               if (popAmt == POP_TWO) begin
                  if (!w_ge2) w_uf_set = 1'b1;
                  else        w_count_d = r_count - CW'(2);
               end else begin
                  if (w_empty) w_uf_set = 1'b1;
                  else         w_count_d = r_count - CW'(1);
               end
            end
            ES_DUP: begin
               if (w_empty) begin
                  w_uf_set = 1'b1;
               end else if (w_full) begin
                  w_ovf_set = 1'b1;
               end else begin
                  w_we_a    = 1'b1;
                  w_wdata_a = Top;
                  w_count_d = r_count + CW'(1);
               end
            end
            ES_FLIP: begin
               if (!w_ge2) begin
                  w_uf_set = 1'b1;
               end else begin
                  // Swap in one edge: A writes Second into top slot, B writes Top below.
                  w_we_a    = 1'b1;
                  w_waddr_a = w_top_idx;
                  w_wdata_a = Second;
                  w_we_b    = 1'b1;
                  w_waddr_b = w_sec_idx;
                  w_wdata_b = Top;
               end
            end
            default: ;
         endcase
      end
      // An edge taken while reset is held must not leave a stray write behind.
      if (!Reset_n) begin
         w_we_a = 1'b0;
         w_we_b = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_uf    <= 1'b0;
      end else begin
         r_count <= w_count_d;
         // A new error in the clearing cycle still sets the flag.
         r_ovf   <= (r_ovf & ~ErrClr) | w_ovf_set;
         r_uf    <= (r_uf  & ~ErrClr) | w_uf_set;
      end
   end

   assign Count     = r_count;
   assign Empty     = w_empty;
   assign Full      = w_full;
   assign Overflow  = r_ovf;
   assign Underflow = r_uf;

endmodule

// File: tb/tb_expression_stack.sv
module tb_expression_stack;
   import expression_stack_pkg::*;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned CW    = 5;

   logic             CLK = 1'b0;
   logic             Reset_n;
   logic             ESAct;
   logic [1:0]       ESOp;
   logic             popAmt;
   logic [WIDTH-1:0] PushData;
   logic             ErrClr;
   logic [WIDTH-1:0] Top, Second;
   logic [CW-1:0]    Count;
   logic             Empty, Full, Overflow, Underflow;

   int n_tests = 0;
   int n_fail  = 0;

   expression_stack #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .CW    (CW)
   ) dut (
      .CLK       (CLK),
      .Reset_n   (Reset_n),
      .ESAct     (ESAct),
      .ESOp      (ESOp),
      .popAmt    (popAmt),
      .PushData  (PushData),
      .ErrClr    (ErrClr),
      .Top       (Top),
      .Second    (Second),
      .Count     (Count),
      .Empty     (Empty),
      .Full      (Full),
      .Overflow  (Overflow),
      .Underflow (Underflow)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive at negedge, commit at posedge, then sample 1 time unit later.
   task automatic cmd(input logic act, input logic [1:0] op, input logic amt,
                      input logic [WIDTH-1:0] data, input logic clr);
      @(negedge CLK);
      ESAct    = act;
      ESOp     = op;
      popAmt   = amt;
      PushData = data;
      ErrClr   = clr;
      @(posedge CLK);
      #1;
      ESAct  = 1'b0;
      ErrClr = 1'b0;
   endtask

   task automatic push(input logic [WIDTH-1:0] d);
      cmd(1'b1, ES_PUSH, POP_ONE, d, 1'b0);
   endtask

   task automatic check_stack(input string tag, input logic [WIDTH-1:0] t,
                              input logic [WIDTH-1:0] s, input logic [CW-1:0] c);
      check_eq({tag, ".top"}, 32'(Top), 32'(t));
      check_eq({tag, ".second"}, 32'(Second), 32'(s));
      check_eq({tag, ".count"}, 32'(Count), 32'(c));
   endtask

   initial begin
      Reset_n  = 1'b0;
      ESAct    = 1'b0;
      ESOp     = 2'b00;
      popAmt   = 1'b0;
      PushData = '0;
      ErrClr   = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      Reset_n = 1'b1;
      #1;

      // 1. reset state
      check_stack("reset", 16'h0, 16'h0, 5'd0);
      check_eq("reset.empty", 32'(Empty), 32'd1);
      check_eq("reset.full", 32'(Full), 32'd0);
      check_eq("reset.ovf", 32'(Overflow), 32'd0);
      check_eq("reset.uf", 32'(Underflow), 32'd0);

      // 2. push/push/flip
      push(16'h0011);
      check_stack("push1", 16'h0011, 16'h0, 5'd1);
      push(16'h0022);
      check_stack("push2", 16'h0022, 16'h0011, 5'd2);
      cmd(1'b1, ES_FLIP, POP_ONE, 16'h0, 1'b0);
      check_stack("flip", 16'h0011, 16'h0022, 5'd2);

      // 3. dup then pop-two, then push sees updated count; stack bottom->top 22,11
      push(16'h00AB);
      cmd(1'b1, ES_DUP, POP_ONE, 16'h0, 1'b0);
      check_stack("dup", 16'h00AB, 16'h00AB, 5'd4);
      cmd(1'b1, ES_POP, POP_TWO, 16'h0, 1'b0);
      check_stack("pop2", 16'h0011, 16'h0022, 5'd2);
      push(16'h0033);
      check_stack("pop_then_push", 16'h0033, 16'h0011, 5'd3);
      cmd(1'b0, ES_PUSH, POP_ONE, 16'hDEAD, 1'b0);
      check_stack("idle_hold", 16'h0033, 16'h0011, 5'd3);
      cmd(1'b1, ES_POP, POP_ONE, 16'h0, 1'b0);
      cmd(1'b1, ES_POP, POP_TWO, 16'h0, 1'b0);
      check_eq("drain.empty", 32'(Empty), 32'd1);

      // 4. fill, overflow, clear
      for (int i = 1; i <= 16; i++) push(16'(i));
      check_stack("fill", 16'd16, 16'd15, 5'd16);
      check_eq("fill.full", 32'(Full), 32'd1);
      check_eq("fill.ovf", 32'(Overflow), 32'd0);
      push(16'hFFFF);
      check_stack("push_full", 16'd16, 16'd15, 5'd16);
      check_eq("push_full.ovf", 32'(Overflow), 32'd1);
      cmd(1'b0, ES_PUSH, POP_ONE, 16'h0, 1'b1);
      check_eq("errclr.ovf", 32'(Overflow), 32'd0);
      cmd(1'b1, ES_DUP, POP_ONE, 16'h0, 1'b0);
      check_stack("dup_full", 16'd16, 16'd15, 5'd16);
      check_eq("dup_full.ovf", 32'(Overflow), 32'd1);
      cmd(1'b1, ES_PUSH, POP_ONE, 16'h1234, 1'b1);
      check_eq("clr_vs_set.ovf", 32'(Overflow), 32'd1);
      cmd(1'b0, ES_PUSH, POP_ONE, 16'h0, 1'b1);
      check_eq("errclr2.ovf", 32'(Overflow), 32'd0);

      // 5. underflow cases at Count=1
      for (int i = 0; i < 7; i++) cmd(1'b1, ES_POP, POP_TWO, 16'h0, 1'b0);
      cmd(1'b1, ES_POP, POP_ONE, 16'h0, 1'b0);
      check_stack("down_to_1", 16'd1, 16'h0, 5'd1);
      check_eq("down_to_1.uf", 32'(Underflow), 32'd0);
      cmd(1'b1, ES_POP, POP_TWO, 16'h0, 1'b0);
      check_stack("pop2_at1", 16'd1, 16'h0, 5'd1);
      check_eq("pop2_at1.uf", 32'(Underflow), 32'd1);
      cmd(1'b1, ES_FLIP, POP_ONE, 16'h0, 1'b0);
      check_stack("flip_at1", 16'd1, 16'h0, 5'd1);
      cmd(1'b1, ES_POP, POP_ONE, 16'h0, 1'b0);
      check_stack("pop1_at1", 16'h0, 16'h0, 5'd0);
      check_eq("pop1_at1.empty", 32'(Empty), 32'd1);
      cmd(1'b0, ES_PUSH, POP_ONE, 16'h0, 1'b1);
      check_eq("errclr.uf", 32'(Underflow), 32'd0);
      cmd(1'b1, ES_DUP, POP_ONE, 16'h0, 1'b0);
      check_eq("dup_empty.uf", 32'(Underflow), 32'd1);
      check_eq("dup_empty.ovf", 32'(Overflow), 32'd0);
      check_eq("dup_empty.count", 32'(Count), 32'd0);
      cmd(1'b1, ES_POP, POP_ONE, 16'h0, 1'b0);
      check_eq("pop1_empty.count", 32'(Count), 32'd0);

      // 6. async reset mid-command
      push(16'h0044);
      push(16'h0055);
      @(negedge CLK);
      ESAct    = 1'b1;
      ESOp     = ES_PUSH;
      PushData = 16'h0066;
      #2;
      Reset_n = 1'b0;
      #1;
      check_stack("async_rst", 16'h0, 16'h0, 5'd0);
      check_eq("async_rst.uf", 32'(Underflow), 32'd0);
      @(posedge CLK);
      #1;
      ESAct = 1'b0;
      @(negedge CLK);
      Reset_n = 1'b1;
      #1;
      check_stack("after_rst", 16'h0, 16'h0, 5'd0);
      push(16'h0077);
      check_stack("push_after_rst", 16'h0077, 16'h0, 5'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
